// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a parallel pattern on Start and shifts it out
// MSB-first on w, repeated Reps+1 times with GAP idle cycles between passes.
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
  input  logic                         Abort,
  input  logic [WIDTH-1:0]             Data,
  input  logic [$clog2(WIDTH+1)-1:0]   Len,
  input  logic [REP_W-1:0]             Reps,
  output logic                         w,
  output logic                         Valid,
  output logic                         Busy,
  output logic                         Done
);

  localparam int unsigned LW = $clog2(WIDTH + 1);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state,   state_n;
  logic [WIDTH-1:0] pat,     pat_n;
  logic [BW-1:0]    top,     top_n;
  logic [BW-1:0]    bitcnt,  bitcnt_n;
  logic [REP_W-1:0] passcnt, passcnt_n;
  logic [GW-1:0]    gapcnt,  gapcnt_n;
  logic             w_n, valid_n, busy_n, done_n;

  logic [LW-1:0]    leff;
  logic [BW-1:0]    leff_m1;

  // Out-of-range lengths fall back to the full pattern width
  assign leff    = ((Len == '0) || (Len > LW'(WIDTH))) ? LW'(WIDTH) : Len;
  assign leff_m1 = BW'(leff - LW'(1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= S_IDLE;
      pat     <= '0;
      top     <= '0;
      bitcnt  <= '0;
      passcnt <= '0;
      gapcnt  <= '0;
      w       <= 1'b0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat     <= pat_n;
      top     <= top_n;
      bitcnt  <= bitcnt_n;
      passcnt <= passcnt_n;
      gapcnt  <= gapcnt_n;
      w       <= w_n;
      Valid   <= valid_n;
      Busy    <= busy_n;
      Done    <= done_n;
    end
  end

  // Next-state and next-output logic; outputs describe the cycle after the edge
  always_comb begin
    state_n   = state;
    pat_n     = pat;
    top_n     = top;
    bitcnt_n  = bitcnt;
    passcnt_n = passcnt;
    gapcnt_n  = gapcnt;
    w_n       = 1'b0;
    valid_n   = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start && !Abort) begin
          pat_n     = Data;
          top_n     = leff_m1;
          bitcnt_n  = leff_m1;
          passcnt_n = Reps;
          w_n       = Data[leff_m1];
          valid_n   = 1'b1;
          busy_n    = 1'b1;
          state_n   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy_n = 1'b1;
        if (bitcnt != '0) begin
          bitcnt_n = bitcnt - BW'(1);
          w_n      = pat[bitcnt - BW'(1)];
          valid_n  = 1'b1;
        end else if (passcnt != '0) begin
          passcnt_n = passcnt - REP_W'(1);
          if (GAP > 0) begin
            state_n  = S_GAP;
            gapcnt_n = GW'(GAP - 1);
          end else begin
            bitcnt_n = top;
            w_n      = pat[top];
            valid_n  = 1'b1;
          end
        end else begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end

      S_GAP: begin
        busy_n = 1'b1;
        if (gapcnt != '0) begin
          gapcnt_n = gapcnt - GW'(1);
        end else begin
          state_n  = S_SHIFT;
          bitcnt_n = top;
          w_n      = pat[top];
          valid_n  = 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Abort overrides everything except reset
    if (Abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      w_n     = 1'b0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: two instances (GAP=2 and GAP=0) share stimulus,
// a negedge monitor checks the selected instance's bits and Done timing against queues.
module tb_seq_pattern_tx;

  typedef struct {
    int   c;
    logic b;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic [7:0] Data = 8'h00;
  logic [3:0] Len = 4'd0;
  logic [3:0] Reps = 4'd0;

  logic w2, v2, b2, d2;
  logic w0, v0, b0, d0;
  logic sel = 1'b0;
  logic mw, mv, mb, md;
  logic mon_en = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t bq[$];
  int   dq[$];

  seq_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(2)) dut_g2 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Data(Data), .Len(Len),
    .Reps(Reps), .w(w2), .Valid(v2), .Busy(b2), .Done(d2)
  );

  seq_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(0)) dut_g0 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Data(Data), .Len(Len),
    .Reps(Reps), .w(w0), .Valid(v0), .Busy(b0), .Done(d0)
  );

  assign mw = sel ? w0 : w2;
  assign mv = sel ? v0 : v2;
  assign mb = sel ? b0 : b2;
  assign md = sel ? d0 : d2;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Valid cycle consumes one expected bit, every Done one expected Done
  always @(negedge Clk) begin
    if (mon_en) begin
      if (mv === 1'b1) begin
        if (bq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = bq.pop_front();
          chk("bit_cycle", cyc, e.c);
          chk("bit_value", int'(mw), int'(e.b));
        end
      end else begin
        chk("w_idle_zero", int'(mw), 0);
      end
      if (md === 1'b1) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          int dc;
          dc = dq.pop_front();
          chk("done_cycle", cyc, dc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
  endtask

  // Issue Start in the current cycle c0 and push the expected stream
  task automatic start_tx(input logic [7:0] d, input int len, input int reps);
    int leff, gap, c0;
    leff = (len == 0 || len > 8) ? 8 : len;
    gap  = sel ? 0 : 2;
    c0   = cyc;
    Start = 1'b1;
    Data  = d;
    Len   = 4'(len);
    Reps  = 4'(reps);
    for (int p = 0; p <= reps; p++)
      for (int i = leff - 1; i >= 0; i--)
        bq.push_back('{c0 + 1 + p * (leff + gap) + (leff - 1 - i), d[i]});
    dq.push_back(c0 + (reps + 1) * leff + reps * gap + 1);
    tick(1);
    Start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || dq.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    chk("drain_pending", bq.size() + dq.size(), 0);
    bq.delete();
    dq.delete();
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(1);
    do_reset();
    chk("rst_w",     int'(w2 | w0), 0);
    chk("rst_valid", int'(v2 | v0), 0);
    chk("rst_busy",  int'(b2 | b0), 0);
    chk("rst_done",  int'(d2 | d0), 0);
    mon_en = 1'b1;

    // Full-width single pass, with an ignored Start in cycle 4 and a Start in cycle 10
    sel = 1'b0;
    start_tx(8'hB2, 8, 0);
    chk("t1_busy_c1", int'(mb), 1);
    tick(3);
    Start = 1'b1;
    Data  = 8'hFF;
    tick(1);
    Start = 1'b0;
    tick(4);
    chk("t1_busy_c9", int'(mb), 1);
    chk("t1_done_c9", int'(md), 1);
    tick(1);
    chk("t1_busy_c10", int'(mb), 0);
    start_tx(8'h3C, 8, 0);
    chk("t4_busy_c11", int'(mb), 1);
    drain();

    // Repeat with GAP=2
    do_reset();
    start_tx(8'h06, 3, 1);
    tick(3);
    chk("t2_gap1_busy",  int'(mb), 1);
    chk("t2_gap1_valid", int'(mv), 0);
    tick(1);
    chk("t2_gap2_busy",  int'(mb), 1);
    chk("t2_gap2_valid", int'(mv), 0);
    drain();

    // Len rules
    start_tx(8'h81, 0, 0);
    drain();
    sel = 1'b1;
    do_reset();
    start_tx(8'h01, 1, 2);
    drain();
    start_tx(8'h01, 1, 15);
    drain();
    start_tx(8'h5A, 12, 1);
    drain();

    // Abort in cycle 3
    sel = 1'b0;
    do_reset();
    start_tx(8'hB2, 8, 0);
    tick(2);
    Abort = 1'b1;
    tick(1);
    Abort = 1'b0;
    bq.delete();
    dq.delete();
    chk("abort_busy",  int'(mb), 0);
    chk("abort_valid", int'(mv), 0);
    chk("abort_w",     int'(mw), 0);
    tick(12);

    // Rst in cycle 3
    start_tx(8'hB2, 8, 0);
    tick(2);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    bq.delete();
    dq.delete();
    chk("rst_mid_busy",  int'(mb), 0);
    chk("rst_mid_valid", int'(mv), 0);
    chk("rst_mid_done",  int'(md), 0);
    tick(12);

    // Abort+Start together in IDLE
    Start = 1'b1;
    Abort = 1'b1;
    Data  = 8'hFF;
    Len   = 4'd8;
    tick(1);
    Start = 1'b0;
    Abort = 1'b0;
    chk("abort_start_busy", int'(mb), 0);
    tick(12);

    // Pattern is immune to input changes after acceptance
    start_tx(8'hA5, 8, 0);
    for (int k = 0; k < 8; k++) begin
      Data = 8'($urandom);
      Len  = 4'($urandom);
      Reps = 4'($urandom);
      tick(1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
